// File: rtl/decoder_scan_seq.sv
// rtl/decoder_scan_seq.sv - scan sequencer driving select/enable of a 3-to-8 decoder stage
//
// Purpose:
//   Steps through the set bits of a channel mask in ascending order. Each
//   channel is held with EN high for DWELL+1 cycles. Between channels there
//   is one EN-low break-before-make cycle. Supports single-pass (DONE pulse
//   on completion) and continuous wrap, with START/STOP control.
//
// Ports:
//   CLK    in   clock, rising edge
//   RST    in   asynchronous active-high reset
//   START  in   begin scan (only honoured in IDLE with STOP low and MASK!=0)
//   STOP   in   abort scan, checked every cycle, beats START and completion
//   MODE   in   0 = single pass, 1 = continuous wrap (sampled at wrap time)
//   MASK   in   channel enable mask, latched on accepted START
//   DWELL  in   hold time minus one, latched on accepted START
//   A,B,C  out  channel select, A = MSB
//   EN     out  decoder enable
//   BUSY   out  high in any non-IDLE state
//   DONE   out  one-cycle pulse at normal single-pass completion

module decoder_scan_seq #(
  parameter int DWELL_W = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic               STOP,
  input  logic               MODE,
  input  logic [7:0]         MASK,
  input  logic [DWELL_W-1:0] DWELL,
  output logic               A,
  output logic               B,
  output logic               C,
  output logic               EN,
  output logic               BUSY,
  output logic               DONE
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_BLANK  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         sel_q, sel_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [7:0]         mask_q, mask_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;

  // Lowest set bit of m at index >= from. Result is {found, index}.
  function automatic logic [3:0] first_set(input logic [7:0] m, input int from);
    logic [3:0] r;
    r = 4'b0;
    for (int i = 7; i >= 0; i--) begin
      if (i >= from && m[i]) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  logic [3:0] lo_live;  // lowest channel of the incoming MASK
  logic [3:0] lo_lat;   // lowest channel of the latched mask (wrap target)
  logic [3:0] nxt_hi;   // next channel above the current one

  assign lo_live = first_set(MASK, 0);
  assign lo_lat  = first_set(mask_q, 0);
  assign nxt_hi  = first_set(mask_q, int'(sel_q) + 1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      sel_q   <= 3'd0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      mask_q  <= 8'd0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      dwell_q <= dwell_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    dwell_d = dwell_q;

    unique case (state_q)
      S_IDLE: begin
        en_d   = 1'b0;
        busy_d = 1'b0;
        // lo_live[3] doubles as the MASK != 0 test
        if (START && !STOP && lo_live[3]) begin
          mask_d  = MASK;
          dwell_d = DWELL;
          sel_d   = lo_live[2:0];
          en_d    = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_ACTIVE;
        end
      end

      S_ACTIVE: begin
        if (STOP) begin
          en_d    = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (cnt_q == dwell_q) begin
          // Every exit drops EN on the same edge the select may move, so the
          // decoder never sees a select change while enabled.
          en_d  = 1'b0;
          cnt_d = '0;
          if (nxt_hi[3]) begin
            sel_d   = nxt_hi[2:0];
            state_d = S_BLANK;
          end else if (MODE && lo_lat[3]) begin
            sel_d   = lo_lat[2:0];
            state_d = S_BLANK;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_BLANK: begin
        if (STOP) begin
          en_d    = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          en_d    = 1'b1;
          state_d = S_ACTIVE;
        end
      end

      default: begin
        en_d    = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign A    = sel_q[2];
  assign B    = sel_q[1];
  assign C    = sel_q[0];
  assign EN   = en_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: doc/decoder_scan_seq.md
Name: decoder_scan_seq

Overview:
- Sequencer that drives the select inputs (A,B,C) and enable (EN) of the 3-to-8 line decoder stage directly downstream.
- Steps through a masked subset of the eight channels in ascending order. Each channel is held for a programmable dwell time.
- Between channels it inserts a one-cycle break-before-make gap.
- Supports single-pass and continuous scan, with start/stop control and busy/done status.

Parameters:
- DWELL_W, 8, width of DWELL input and internal dwell counter.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  reset, asynchronous, active-high.
- START  input  1  begin scan; sampled only in IDLE.
- STOP  input  1  abort scan; sampled every cycle.
- MODE  input  1  0 = single pass, 1 = continuous wrap.
- MASK  input  8  channel enable mask; bit i = channel i; latched on accepted START.
- DWELL  input  DWELL_W  channel hold time = DWELL+1 cycles; latched on accepted START.
- A  output  1  select MSB (channel bit 2).
- B  output  1  select bit 1.
- C  output  1  select LSB (bit 0).
- EN  output  1  decoder enable.
- BUSY  output  1  high in any non-IDLE state.
- DONE  output  1  one-cycle pulse at normal single-pass completion.

Behaviour:
- Reset (async, RST=1): state IDLE; A=B=C=0, EN=0, BUSY=0, DONE=0; dwell counter 0; latched mask/dwell 0. All outputs registered.
- States: IDLE, ACTIVE, BLANK.
- IDLE:
  - EN=0, BUSY=0; A,B,C hold their last value.
  - START=1, STOP=0 and MASK!=0 → at that edge:
    - latch MASK and DWELL;
    - {A,B,C} = index of lowest set MASK bit;
    - EN=1, BUSY=1, counter=0; go to ACTIVE.
  - START with MASK==0: ignored; stay IDLE, no DONE.
- ACTIVE:
  - EN=1; counter increments each cycle.
  - When counter==latched DWELL (EN has been high DWELL+1 cycles), at that edge:
    - Next higher set bit exists in latched mask: {A,B,C}=that index, EN=0, counter=0 → BLANK.
    - No higher set bit, MODE=1: {A,B,C}=lowest set bit (may be the same channel), EN=0 → BLANK.
    - No higher set bit, MODE=0: EN=0, BUSY=0, DONE=1 for one cycle → IDLE; A,B,C hold the last channel.
- BLANK: exactly one cycle with EN=0 and the new select stable; next edge EN=1 → ACTIVE.
- MODE is sampled live at each wrap decision. MASK and DWELL changes during a scan have no effect.
- STOP=1 in ACTIVE/BLANK: at that edge EN=0, BUSY=0, go to IDLE; DONE stays 0. STOP wins over START and over a simultaneous completion (no DONE).
- START while BUSY: ignored.
- Invariants:
  - EN never high while A,B,C change at the same edge.
  - EN high implies the select equals a set bit of the latched mask.
- DWELL=0: each channel EN high 1 cycle, then 1 BLANK cycle.
- Counter width DWELL_W, no overflow: compare is equality with the latched DWELL ≤ 2^DWELL_W−1.
- Reset asserted mid-scan: outputs go to reset values immediately (async), no DONE. After RST release the block waits in IDLE for a new START.

Test Plan:
- Reset: assert RST mid-ACTIVE with EN=1 → EN, BUSY, DONE, A,B,C go to 0 without a clock edge; after release, IDLE until START.
- Single pass: MASK=8'b0010_0101, DWELL=2, MODE=0, pulse START → {A,B,C}=0,2,5 with EN high 3 cycles each and 1 EN-low BLANK between; BUSY high 11 cycles; DONE pulses once on the cycle after channel 5 ends.
- Continuous wrap: MASK=8'b1000_0010, DWELL=0, MODE=1 → EN pattern 1,0 repeating with select 1,7,1,7…; set MODE=0 during channel 7 → after channel 7, DONE pulses and IDLE.
- Single channel continuous: MASK=8'b0000_1000, DWELL=1, MODE=1 → select stays 3, EN 1,1,0 repeating; no DONE.
- STOP precedence: STOP during BLANK → IDLE next edge, EN=0, DONE=0. START+STOP together in IDLE → stays IDLE. STOP on the final-dwell cycle of a single pass → no DONE.
- Ignored inputs: START with MASK=0 → no BUSY. START during a scan → no restart. Changing MASK/DWELL mid-scan → original sequence and timing unchanged.
